rc_osc_mon: RTL

Digital supervisor for the brownout RC oscillator, running on the system clock `ck`. It drives `osc_ena`, waits a fixed start-up interval, then repeatedly counts rising edges of the asynchronous `osc_ck` over a fixed window of `ck` cycles. Each window's count is published, and the oscillator is classified as ok, fast or slow, with `osc_ok` qualified over consecutive windows.

---
 rtl/rc_osc_mon_pkg.sv | 21 ++
 rtl/rc_osc_sync.sv | 26 ++
 rtl/rc_osc_mon.sv | 126 ++++++++++++
 3 files changed

// File: rtl/rc_osc_mon_pkg.sv
// Shared types and default parameters for the brownout RC oscillator monitor.
package rc_osc_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    MEAS,
    EVAL
  } state_t;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_STARTUP_CYCLES = 256;
  localparam int DEF_WIN_CYCLES     = 1000;
  localparam int DEF_CNT_W          = 16;
  localparam int DEF_MIN_EDGES      = 40;
  localparam int DEF_MAX_EDGES      = 60;
  localparam int DEF_OK_WINDOWS     = 2;

  localparam logic [DEF_CNT_W-1:0] CNT_SAT = {DEF_CNT_W{1'b1}};

endpackage

// File: rtl/rc_osc_sync.sv
// Synchronizes the asynchronous oscillator clock into ck and flags its rising edges.
module rc_osc_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic ck,
  input  logic resetb,
  input  logic osc_ck,
  output logic rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge ck) begin
    if (!resetb) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], osc_ck};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/rc_osc_mon.sv
// RC oscillator supervisor: enable, start-up wait, then continuous windowed edge counting and range qualification.
module rc_osc_mon
  import rc_osc_mon_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int STARTUP_CYCLES = DEF_STARTUP_CYCLES,
  parameter int WIN_CYCLES     = DEF_WIN_CYCLES,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int MIN_EDGES      = DEF_MIN_EDGES,
  parameter int MAX_EDGES      = DEF_MAX_EDGES,
  parameter int OK_WINDOWS     = DEF_OK_WINDOWS
) (
  input  logic             ck,
  input  logic             resetb,
  input  logic             dvdd,
  input  logic             dvss,
  input  logic             ena,
  input  logic             osc_ck,
  output logic             osc_ena,
  output logic [CNT_W-1:0] osc_cnt,
  output logic             cnt_vld,
  output logic             osc_ok,
  output logic             osc_fast,
  output logic             osc_slow
);

  localparam int TMR_MAX = (STARTUP_CYCLES > WIN_CYCLES) ? STARTUP_CYCLES : WIN_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int GOOD_W  = $clog2(OK_WINDOWS + 1);
  localparam logic [CNT_W-1:0] EDGE_SAT = {CNT_W{1'b1}};

  state_t              r_state;
  logic [TMR_W-1:0]    r_tmr;
  logic [CNT_W-1:0]    r_edge;
  logic [GOOD_W-1:0]   r_good;
  logic                w_rise;
  logic                w_fast;
  logic                w_slow;
  logic                w_in_range;
  logic [GOOD_W-1:0]   w_good_inc;
  logic                w_unused_supply;

  assign w_unused_supply = dvdd ^ dvss;

  rc_osc_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .ck    (ck),
    .resetb(resetb),
    .osc_ck(osc_ck),
    .rise  (w_rise)
  );

  always_comb begin
    w_fast     = int'(r_edge) > MAX_EDGES;
    w_slow     = int'(r_edge) < MIN_EDGES;
    w_in_range = !w_fast && !w_slow;
    w_good_inc = (r_good == GOOD_W'(OK_WINDOWS)) ? r_good : r_good + GOOD_W'(1);
  end

  always_ff @(posedge ck) begin
    if (!resetb) begin
      r_state  <= IDLE;
      r_tmr    <= '0;
      r_edge   <= '0;
      r_good   <= '0;
      osc_ena  <= 1'b0;
      osc_cnt  <= '0;
      cnt_vld  <= 1'b0;
      osc_ok   <= 1'b0;
      osc_fast <= 1'b0;
      osc_slow <= 1'b0;
    end else if (!ena) begin
      r_state  <= IDLE;
      r_edge   <= '0;
      r_good   <= '0;
      osc_ena  <= 1'b0;
      cnt_vld  <= 1'b0;
      osc_ok   <= 1'b0;
      osc_fast <= 1'b0;
      osc_slow <= 1'b0;
    end else begin
      cnt_vld <= 1'b0;
      case (r_state)
        IDLE: begin
          r_state <= START;
          r_tmr   <= TMR_W'(STARTUP_CYCLES);
        end
        START: begin
          osc_ena <= 1'b1;
          if (r_tmr == '0) begin
            r_state <= MEAS;
            r_tmr   <= TMR_W'(WIN_CYCLES - 1);
            r_edge  <= '0;
          end else begin
            r_tmr <= r_tmr - TMR_W'(1);
          end
        end
        MEAS: begin
          if (w_rise && (r_edge != EDGE_SAT)) r_edge <= r_edge + CNT_W'(1);
          if (r_tmr == '0) r_state <= EVAL;
          else             r_tmr   <= r_tmr - TMR_W'(1);
        end
        EVAL: begin
          r_state  <= MEAS;
          r_tmr    <= TMR_W'(WIN_CYCLES - 1);
          osc_cnt  <= r_edge;
          cnt_vld  <= 1'b1;
          osc_fast <= w_fast;
          osc_slow <= w_slow;
          if (w_in_range) begin
            r_good <= w_good_inc;
            osc_ok <= (w_good_inc == GOOD_W'(OK_WINDOWS));
          end else begin
            r_good <= '0;
            osc_ok <= 1'b0;
          end
          // An edge seen during EVAL opens the next window's count so none is lost.
          r_edge <= CNT_W'(w_rise);
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
